// File: rtl/ir_nec_pkg.sv
// Shared types, NEC nominal timings and the NEC-code-to-robot-command map for the IR decoder.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        CMD_ON    = 3'd0,
        CMD_OFF   = 3'd1,
        CMD_FWD   = 3'd2,
        CMD_BACK  = 3'd3,
        CMD_LEFT  = 3'd4,
        CMD_RIGHT = 3'd5,
        CMD_STOP  = 3'd6
    } cmd_t;

    typedef struct packed {
        logic hit;
        cmd_t cmd;
    } nec_map_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        CHECK
    } state_t;

    localparam int NEC_LEAD_MARK_US   = 9000;
    localparam int NEC_LEAD_SPACE_US  = 4500;
    localparam int NEC_RPT_SPACE_US   = 2250;
    localparam int NEC_BIT_MARK_US    = 562;
    localparam int NEC_SPACE0_US      = 562;
    localparam int NEC_SPACE1_US      = 1687;
    localparam int NEC_TIMEOUT_US     = 12000;

    // Scales a microsecond duration by pct percent into clock cycles (floor).
    function automatic int us_to_cycles(input longint us, input longint hz, input longint pct);
        return int'((us * hz * pct) / 64'sd100000000);
    endfunction

    function automatic nec_map_t nec_to_cmd(input logic [7:0] code);
        nec_map_t m;
        m.hit = 1'b1;
        m.cmd = CMD_ON;
        case (code)
            8'h45:   m.cmd = CMD_ON;
            8'h46:   m.cmd = CMD_OFF;
            8'h18:   m.cmd = CMD_FWD;
            8'h52:   m.cmd = CMD_BACK;
            8'h08:   m.cmd = CMD_LEFT;
            8'h5A:   m.cmd = CMD_RIGHT;
            8'h1C:   m.cmd = CMD_STOP;
            default: m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ir_nec_decoder_timer.sv
// ir_pulse_timer: synchronizes the raw IR line, flags its edges and measures the time since the last edge.
module ir_pulse_timer #(
    parameter int T_TIMEOUT = 300,
    parameter int DUR_W     = $clog2(T_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ir_in,
    output logic             rise,
    output logic             fall,
    output logic [DUR_W-1:0] dur
);

    localparam logic [DUR_W-1:0] DUR_MAX = DUR_W'(T_TIMEOUT);

    logic sync1, sync2, level_q;

    // Flops reset to the idle (high) line level so reset release never looks like a mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync1   <= ir_in;
            sync2   <= sync1;
            level_q <= sync2;
        end
    end

    assign rise = sync2 & ~level_q;
    assign fall = ~sync2 & level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dur <= '0;
        end else if (rise || fall) begin
            dur <= '0;
        end else if (dur != DUR_MAX) begin
            dur <= dur + DUR_W'(1);
        end
    end

endmodule

// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder: decodes NEC IR frames into a 3-bit robot command held valid for one consumer sclk period.
// Define IR_REPEAT_EN to re-assert the last accepted command on NEC repeat frames.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int         clk_hz  = 25000000,
    parameter int         sclk_hz = 256,
    parameter logic [7:0] ADDR    = 8'h00,
    parameter int         TOL_PCT = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_in,
    output logic [2:0] command,
    output logic       ir_ready,
    output logic       frame_err
);

    localparam int T_TIMEOUT = us_to_cycles(NEC_TIMEOUT_US, clk_hz, 100);
    localparam int DUR_W     = $clog2(T_TIMEOUT + 1);
    localparam int LM_LO = us_to_cycles(NEC_LEAD_MARK_US,  clk_hz, 100 - TOL_PCT);
    localparam int LM_HI = us_to_cycles(NEC_LEAD_MARK_US,  clk_hz, 100 + TOL_PCT);
    localparam int LS_LO = us_to_cycles(NEC_LEAD_SPACE_US, clk_hz, 100 - TOL_PCT);
    localparam int LS_HI = us_to_cycles(NEC_LEAD_SPACE_US, clk_hz, 100 + TOL_PCT);
    localparam int RS_LO = us_to_cycles(NEC_RPT_SPACE_US,  clk_hz, 100 - TOL_PCT);
    localparam int RS_HI = us_to_cycles(NEC_RPT_SPACE_US,  clk_hz, 100 + TOL_PCT);
    localparam int BM_LO = us_to_cycles(NEC_BIT_MARK_US,   clk_hz, 100 - TOL_PCT);
    localparam int BM_HI = us_to_cycles(NEC_BIT_MARK_US,   clk_hz, 100 + TOL_PCT);
    localparam int S0_LO = us_to_cycles(NEC_SPACE0_US,     clk_hz, 100 - TOL_PCT);
    localparam int S0_HI = us_to_cycles(NEC_SPACE0_US,     clk_hz, 100 + TOL_PCT);
    localparam int S1_LO = us_to_cycles(NEC_SPACE1_US,     clk_hz, 100 - TOL_PCT);
    localparam int S1_HI = us_to_cycles(NEC_SPACE1_US,     clk_hz, 100 + TOL_PCT);
    localparam int HOLD   = clk_hz / sclk_hz;
    localparam int HOLD_W = $clog2(HOLD + 1);

    function automatic logic in_win(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic              rise, fall;
    logic [DUR_W-1:0]  dur;
    int                d;
    state_t            state, state_n;
    logic [4:0]        bit_idx;
    logic [31:0]       shift_reg;
    logic              shift_en, shift_val, idx_clr;
    logic              accept, err, rpt_fire;
    logic              frame_ok;
    nec_map_t          cmd_map;
    logic [HOLD_W-1:0] hold_cnt;
`ifdef IR_REPEAT_EN
    logic              rpt_set, is_rpt, last_valid;
`endif

    ir_pulse_timer #(
        .T_TIMEOUT(T_TIMEOUT),
        .DUR_W    (DUR_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .ir_in(ir_in),
        .rise (rise),
        .fall (fall),
        .dur  (dur)
    );

    assign d       = int'(dur);
    assign cmd_map = nec_to_cmd(shift_reg[23:16]);
    // Bits arrive LSB-first, so the frame reads {~cmd, cmd, ~addr, addr} from MSB down.
    assign frame_ok = (shift_reg[7:0] == ADDR)
                   && ((shift_reg[7:0] ^ shift_reg[15:8]) == 8'hFF)
                   && ((shift_reg[23:16] ^ shift_reg[31:24]) == 8'hFF)
                   && cmd_map.hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_en  = 1'b0;
        shift_val = 1'b0;
        idx_clr   = 1'b0;
        accept    = 1'b0;
        err       = 1'b0;
        rpt_fire  = 1'b0;
`ifdef IR_REPEAT_EN
        rpt_set   = 1'b0;
`endif
        if (state != IDLE && d == T_TIMEOUT) begin
            state_n = IDLE;
            err     = 1'b1;
        end else begin
            case (state)
                IDLE: if (fall) state_n = LEAD_MARK;
                LEAD_MARK: if (rise) state_n = in_win(d, LM_LO, LM_HI) ? LEAD_SPACE : IDLE;
                LEAD_SPACE: if (fall) begin
                    if (in_win(d, LS_LO, LS_HI)) begin
                        state_n = BIT_MARK;
                        idx_clr = 1'b1;
                    end else if (in_win(d, RS_LO, RS_HI)) begin
`ifdef IR_REPEAT_EN
                        state_n = STOP_MARK;
                        rpt_set = 1'b1;
`else
                        state_n = IDLE;
`endif
                    end else begin
                        state_n = IDLE;
                        err     = 1'b1;
                    end
                end
                BIT_MARK: if (rise) begin
                    state_n = in_win(d, BM_LO, BM_HI) ? BIT_SPACE : IDLE;
                    err     = !in_win(d, BM_LO, BM_HI);
                end
                BIT_SPACE: if (fall) begin
                    if (in_win(d, S0_LO, S0_HI) || in_win(d, S1_LO, S1_HI)) begin
                        shift_en  = 1'b1;
                        shift_val = in_win(d, S1_LO, S1_HI);
                        state_n   = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                    end else begin
                        state_n = IDLE;
                        err     = 1'b1;
                    end
                end
                STOP_MARK: if (rise) begin
                    state_n = in_win(d, BM_LO, BM_HI) ? CHECK : IDLE;
                    err     = !in_win(d, BM_LO, BM_HI);
                end
                CHECK: begin
                    state_n = IDLE;
`ifdef IR_REPEAT_EN
                    if (is_rpt) rpt_fire = last_valid;
                    else
`endif
                    if (frame_ok) accept = 1'b1;
                    else          err    = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (idx_clr) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            bit_idx   <= bit_idx + 5'd1;
            shift_reg <= {shift_val, shift_reg[31:1]};
        end
    end

    // A (re)load always restarts the full hold window, so back-to-back commands never drop ir_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            command   <= 3'b000;
            ir_ready  <= 1'b0;
            frame_err <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            frame_err <= err;
            if (accept) begin
                command  <= cmd_map.cmd;
                ir_ready <= 1'b1;
                hold_cnt <= HOLD_W'(HOLD);
            end else if (rpt_fire) begin
                ir_ready <= 1'b1;
                hold_cnt <= HOLD_W'(HOLD);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
                ir_ready <= (hold_cnt != HOLD_W'(1));
            end
        end
    end

`ifdef IR_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_rpt     <= 1'b0;
            last_valid <= 1'b0;
        end else begin
            if (rpt_set)      is_rpt <= 1'b1;
            else if (idx_clr) is_rpt <= 1'b0;
            if (accept) last_valid <= 1'b1;
        end
    end
`endif

endmodule
